// File: rtl/count_sequencer.sv
// count_sequencer: run/pause/step/one-shot sequencer for the 4-bit hex display count.
// Latency: all outputs registered; a control pulse sampled at edge e is visible after e.
// Backpressure: none; control inputs are single-cycle pulses, priority clear > stop > start > step.
// Ports: CLOCK_50/reset_n clock and async active-low reset; start/stop/step/clear control
//   pulses; speed selects the advance period; mode 0 wraps, mode 1 stops at limit;
//   count drives the 7-segment decoder; tick pulses per advance; running/done show state.
module count_sequencer #(
   parameter int CLK_HZ = 50_000_000,
   parameter int DIV_W  = 27
) (
   input  logic       CLOCK_50,
   input  logic       reset_n,
   input  logic       start,
   input  logic       stop,
   input  logic       step,
   input  logic       clear,
   input  logic [1:0] speed,
   input  logic       mode,
   input  logic [3:0] limit,
   output logic [3:0] count,
   output logic       tick,
   output logic       running,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   localparam logic [DIV_W-1:0] RELOAD_2HZ  = DIV_W'(CLK_HZ / 2 - 1);
   localparam logic [DIV_W-1:0] RELOAD_1HZ  = DIV_W'(CLK_HZ - 1);
   localparam logic [DIV_W-1:0] RELOAD_HALF = DIV_W'(2 * CLK_HZ - 1);

   state_t           state, state_nxt;
   logic [DIV_W-1:0] div, div_nxt;
   logic [DIV_W-1:0] reload;
   logic [3:0]       count_nxt;
   logic [3:0]       count_inc;
   logic [3:0]       adv_count;
   logic             adv_done;
   logic             adv;

   // Reload is taken from the live speed input, so a speed change only
   // lands at the next reload and never stretches the current period.
   always_comb begin
      reload = '0;
      case (speed)
         2'b00:   reload = '0;
         2'b01:   reload = RELOAD_2HZ;
         2'b10:   reload = RELOAD_1HZ;
         default: reload = RELOAD_HALF;
      endcase
   end

   // Result of one advance from the current count, evaluated against the
   // live limit/mode so changes to either apply at the next advance.
   always_comb begin
      count_inc = count + 4'd1;
      adv_count = count_inc;
      adv_done  = 1'b0;
      if (count == limit) begin
         adv_count = mode ? count : 4'd0;
         adv_done  = mode;
      end else begin
         adv_done  = mode && (count_inc == limit);
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      div_nxt   = div;
      adv       = 1'b0;
      if (clear) begin
         state_nxt = IDLE;
         count_nxt = 4'd0;
         div_nxt   = reload;
      end else begin
         case (state)
            IDLE: begin
               div_nxt = reload;
               // An asserted stop masks start/step even though it has no effect here.
               if (!stop) begin
                  if (start) begin
                     state_nxt = (mode && (count == limit)) ? DONE : RUN;
                  end else if (step) begin
                     adv = 1'b1;
                  end
               end
            end
            RUN: begin
               // The divider keeps running on the stop edge, so an advance due
               // on that edge still happens and the residual is one lower.
               if (div == '0) begin
                  adv     = 1'b1;
                  div_nxt = reload;
               end else begin
                  div_nxt = div - DIV_W'(1);
               end
               if (stop) begin
                  state_nxt = PAUSE;
               end
            end
            PAUSE: begin
               if (!stop) begin
                  if (start) begin
                     state_nxt = RUN;
                  end else if (step) begin
                     adv = 1'b1;
                  end
               end
            end
            default: begin
               if (!stop && start) begin
                  state_nxt = RUN;
                  count_nxt = 4'd0;
                  div_nxt   = reload;
               end
            end
         endcase
         // A one-shot advance reaching the limit wins over a same-cycle stop.
         if (adv) begin
            count_nxt = adv_count;
            if (adv_done) begin
               state_nxt = DONE;
            end
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         div     <= '0;
         count   <= 4'd0;
         tick    <= 1'b0;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         div     <= div_nxt;
         count   <= count_nxt;
         tick    <= adv;
         running <= (state_nxt == RUN);
         done    <= (state_nxt == DONE);
      end
   end

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed test-plan scenarios plus randomized control pulses,
// every cycle compared against a period/elapsed reference model of the sequencer.
module tb_count_sequencer;

   localparam int CLK_HZ = 8;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic       step;
   logic       clear;
   logic [1:0] speed;
   logic       mode;
   logic [3:0] limit;
   logic [3:0] count;
   logic       tick;
   logic       running;
   logic       done;

   int n_tests = 0;
   int n_fail  = 0;

   typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_t;
   mst_t m_st;
   int   m_cnt;
   int   m_tick;
   int   period;   // cycles per advance latched at the last reload
   int   elapsed;  // cycles spent in the current period

   count_sequencer #(.CLK_HZ(CLK_HZ), .DIV_W(5)) dut (
      .CLOCK_50 (clk),
      .reset_n  (rst_n),
      .start    (start),
      .stop     (stop),
      .step     (step),
      .clear    (clear),
      .speed    (speed),
      .mode     (mode),
      .limit    (limit),
      .count    (count),
      .tick     (tick),
      .running  (running),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int reload_of(input logic [1:0] s);
      case (s)
         2'd0:    return 0;
         2'd1:    return CLK_HZ / 2 - 1;
         2'd2:    return CLK_HZ - 1;
         default: return 2 * CLK_HZ - 1;
      endcase
   endfunction

   task automatic model_reset();
      m_st    = M_IDLE;
      m_cnt   = 0;
      m_tick  = 0;
      period  = 1;
      elapsed = 0;
   endtask

   task automatic model_step();
      int r;
      bit adv;
      r      = reload_of(speed);
      adv    = 1'b0;
      m_tick = 0;
      if (clear) begin
         m_st    = M_IDLE;
         m_cnt   = 0;
         period  = r + 1;
         elapsed = 0;
      end else begin
         case (m_st)
            M_IDLE: begin
               period  = r + 1;
               elapsed = 0;
               if (!stop) begin
                  if (start) m_st = (mode && m_cnt == int'(limit)) ? M_DONE : M_RUN;
                  else if (step) adv = 1'b1;
               end
            end
            M_RUN: begin
               if (elapsed == period - 1) begin
                  adv     = 1'b1;
                  period  = r + 1;
                  elapsed = 0;
               end else begin
                  elapsed++;
               end
               if (stop) m_st = M_PAUSE;
            end
            M_PAUSE: begin
               if (!stop) begin
                  if (start) m_st = M_RUN;
                  else if (step) adv = 1'b1;
               end
            end
            default: begin
               if (!stop && start) begin
                  m_cnt   = 0;
                  period  = r + 1;
                  elapsed = 0;
                  m_st    = M_RUN;
               end
            end
         endcase
         if (adv) begin
            m_tick = 1;
            if (m_cnt == int'(limit)) begin
               if (mode) m_st = M_DONE;
               else m_cnt = 0;
            end else begin
               m_cnt = (m_cnt + 1) % 16;
               if (mode && m_cnt == int'(limit)) m_st = M_DONE;
            end
         end
      end
   endtask

   // One clock: model the edge, then compare all outputs just after it.
   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      chk("count",   int'(count),   m_cnt);
      chk("tick",    int'(tick),    m_tick);
      chk("running", int'(running), (m_st == M_RUN) ? 1 : 0);
      chk("done",    int'(done),    (m_st == M_DONE) ? 1 : 0);
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic pulse(input logic c, input logic sp, input logic st, input logic sx);
      clear = c;
      stop  = sp;
      start = st;
      step  = sx;
      cyc();
      clear = 1'b0;
      stop  = 1'b0;
      start = 1'b0;
      step  = 1'b0;
   endtask

   initial begin
      int r;
      rst_n = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      step  = 1'b0;
      clear = 1'b0;
      speed = 2'd0;
      mode  = 1'b0;
      limit = 4'd15;
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      chk("rst_count",   int'(count),   0);
      chk("rst_tick",    int'(tick),    0);
      chk("rst_running", int'(running), 0);
      chk("rst_done",    int'(done),    0);
      #3 rst_n = 1'b1;

      // 1: wrap at full rate
      pulse(0, 0, 1, 0);
      chk("t1_cnt_start", int'(count), 0);
      chk("t1_run_start", int'(running), 1);
      cycles(17);
      chk("t1_cnt_wrap", int'(count), 1);
      chk("t1_tick_wrap", int'(tick), 1);
      pulse(1, 0, 0, 0);

      // 2: pause and resume with a residual divider
      speed = 2'd1;
      pulse(0, 0, 1, 0);
      cycles(4);
      chk("t2_cnt_e4", int'(count), 1);
      cycles(4);
      chk("t2_cnt_e8", int'(count), 2);
      cycles(1);
      pulse(0, 1, 0, 0);
      chk("t2_run_stop", int'(running), 0);
      cycles(10);
      chk("t2_cnt_paused", int'(count), 2);
      pulse(0, 0, 1, 0);
      cycles(1);
      chk("t2_cnt_r1", int'(count), 2);
      cycles(1);
      chk("t2_cnt_r2", int'(count), 3);
      // step while paused keeps the residual
      cycles(1);
      pulse(0, 1, 0, 0);
      pulse(0, 0, 0, 1);
      chk("t4_pause_step", int'(count), 4);
      pulse(0, 0, 1, 0);
      cycles(2);
      chk("t4_pause_resid", int'(count), 5);
      pulse(1, 0, 0, 0);

      // 3: one-shot to limit
      speed = 2'd0;
      mode  = 1'b1;
      limit = 4'd5;
      pulse(0, 0, 1, 0);
      cycles(5);
      chk("t3_cnt_done", int'(count), 5);
      chk("t3_done", int'(done), 1);
      chk("t3_run_done", int'(running), 0);
      cycles(20);
      chk("t3_cnt_hold", int'(count), 5);
      pulse(0, 0, 1, 0);
      chk("t3_cnt_restart", int'(count), 0);
      chk("t3_run_restart", int'(running), 1);
      pulse(1, 0, 0, 0);

      // 4: step in IDLE with wrap at limit
      mode  = 1'b0;
      limit = 4'd3;
      for (int i = 0; i < 4; i++) begin
         pulse(0, 0, 0, 1);
         chk("t4_step_cnt", int'(count), (i + 1) % 4);
         chk("t4_step_tick", int'(tick), 1);
         cyc();
         chk("t4_step_notick", int'(tick), 0);
      end

      // 5a: stop on the cycle the divider expires
      limit = 4'd15;
      speed = 2'd1;
      pulse(1, 0, 0, 0);
      pulse(0, 0, 1, 0);
      cycles(3);
      pulse(0, 1, 0, 0);
      chk("t5_stop_cnt", int'(count), 1);
      chk("t5_stop_tick", int'(tick), 1);
      chk("t5_stop_run", int'(running), 0);
      cycles(5);
      // 5b: clear and start together
      pulse(1, 0, 1, 0);
      chk("t5_clr_cnt", int'(count), 0);
      chk("t5_clr_run", int'(running), 0);
      // 5c: asynchronous reset mid-run
      speed = 2'd0;
      pulse(0, 0, 1, 0);
      cycles(3);
      #3 rst_n = 1'b0;
      #1;
      chk("t5_arst_count",   int'(count),   0);
      chk("t5_arst_tick",    int'(tick),    0);
      chk("t5_arst_running", int'(running), 0);
      chk("t5_arst_done",    int'(done),    0);
      model_reset();
      #2 rst_n = 1'b1;

      // 6: speed change mid-period
      speed = 2'd3;
      pulse(0, 0, 1, 0);
      cycles(4);
      speed = 2'd0;
      cycles(11);
      chk("t6_cnt_e15", int'(count), 0);
      cycles(1);
      chk("t6_cnt_e16", int'(count), 1);
      cycles(1);
      chk("t6_cnt_e17", int'(count), 2);
      pulse(1, 0, 0, 0);

      // randomized control pulses
      for (int i = 0; i < 3000; i++) begin
         r     = int'($urandom_range(0, 99));
         clear = (r < 2);
         stop  = (r >= 2 && r < 8);
         start = (r >= 8 && r < 20);
         step  = (r >= 20 && r < 30);
         if ($urandom_range(0, 19) == 0) start = 1'b1;
         if ($urandom_range(0, 31) == 0) speed = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 63) == 0) begin
            mode  = 1'($urandom_range(0, 1));
            limit = 4'($urandom_range(0, 15));
         end
         cyc();
      end
      clear = 1'b0;
      stop  = 1'b0;
      start = 1'b0;
      step  = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
